// File: rtl/dmem_mmio_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_mmio_responder_if
//  Description : Core data-port bus plus console TX byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_mmio_responder_if #(
    parameter int N = 32
);
    logic [31:0]  address;
    logic [N-1:0] wdata;
    logic         mem_read;
    logic         mem_write;
    logic [N-1:0] rdata;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (
        output address, wdata, mem_read, mem_write, tx_ready,
        input  rdata, tx_data, tx_valid
    );

    modport slave (
        input  address, wdata, mem_read, mem_write, tx_ready,
        output rdata, tx_data, tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_mmio_responder
//  Description : Data RAM plus MMIO window (console TX FIFO, status, cycle
//                counter) behind the single-cycle core's data port.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder #(
    parameter int          N          = 32,
    parameter int          RAM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    dmem_mmio_responder_if.slave       bus
);
    localparam int c_RAM_AW = $clog2(RAM_WORDS);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;

    logic [N-1:0]        r_ram  [RAM_WORDS];
    logic [7:0]          r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_ovf;
    logic                r_berr;
    logic [31:0]         r_cycle;

    logic                w_ram_hit;
    logic                w_mmio_hit;
    logic [1:0]          w_off;
    logic [c_RAM_AW-1:0] w_idx;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_status_wr;
    logic                w_cycle_wr;
    logic                w_berr_set;
    logic [31:0]         w_status;
    logic [N-1:0]        w_rdata;

    assign w_ram_hit  = (bus.address < 32'(RAM_WORDS * 4));
    assign w_mmio_hit = (bus.address[31:16] == MMIO_BASE[31:16]);
    assign w_off      = bus.address[3:2];
    assign w_idx      = bus.address[c_RAM_AW+1:2];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop      = !w_empty && bus.tx_ready;
    assign w_push_req = bus.mem_write && w_mmio_hit && (w_off == 2'd0);
    // A pop in the same cycle frees the slot the push lands in.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;

    assign w_status_wr = bus.mem_write && w_mmio_hit && (w_off == 2'd1);
    assign w_cycle_wr  = bus.mem_write && w_mmio_hit && (w_off == 2'd2);
    assign w_berr_set  = (bus.mem_read || bus.mem_write) && !w_ram_hit && !w_mmio_hit;

    always_comb begin
        w_status       = '0;
        w_status[0]    = w_empty;
        w_status[1]    = w_full;
        w_status[2]    = r_ovf;
        w_status[3]    = r_berr;
        w_status[15:8] = 8'(r_count);
    end

    always_comb begin
        w_rdata = '0;
        if (bus.mem_read) begin
            if (w_ram_hit) begin
                w_rdata = r_ram[w_idx];
            end else if (w_mmio_hit) begin
                case (w_off)
                    2'd1:    w_rdata = N'(w_status);
                    2'd2:    w_rdata = N'(r_cycle);
                    default: w_rdata = '0;
                endcase
            end
        end
    end

    assign bus.rdata    = w_rdata;
    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

    // Storage arrays carry no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (bus.mem_write && w_ram_hit) begin
            r_ram[w_idx] <= bus.wdata;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_berr   <= 1'b0;
            r_cycle  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_status_wr && bus.wdata[2]) begin
                r_ovf <= 1'b0;
            end

            if (w_berr_set) begin
                r_berr <= 1'b1;
            end else if (w_status_wr && bus.wdata[3]) begin
                r_berr <= 1'b0;
            end

            r_cycle <= w_cycle_wr ? 32'(bus.wdata) : r_cycle + 32'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_mmio_responder
//  Description : Directed and random checks of dmem_mmio_responder against a
//                queue/array based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_responder;
    localparam int N = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_mmio_responder_if #(.N(N)) bus ();

    dmem_mmio_responder #(
        .N(N), .RAM_WORDS(256), .FIFO_DEPTH(8), .MMIO_BASE(32'hFFFF_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_ram [256];
    logic [7:0]  m_q[$];
    logic        m_ovf;
    logic        m_berr;
    logic [31:0] m_cycle;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (m_q.size() == 0);
        s[1]    = (m_q.size() == 8);
        s[2]    = m_ovf;
        s[3]    = m_berr;
        s[15:8] = 8'(m_q.size());
        return s;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] addr, input logic rd);
        if (!rd) return 32'h0;
        if (addr < 32'd1024) return m_ram[addr / 4];
        if (addr[31:16] == 16'hFFFF) begin
            case (addr[3:2])
                2'd1:    return m_status();
                2'd2:    return m_cycle;
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    function automatic logic [7:0] m_txd();
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_berr  = 1'b0;
        m_cycle = 32'h0;
    endtask

    // Applies the effect of one clock edge given the current bus inputs.
    task automatic model_commit();
        logic [31:0] a;
        logic        is_ram, is_mmio;
        a       = bus.address;
        is_ram  = (a < 32'd1024);
        is_mmio = (a[31:16] == 16'hFFFF);
        if (m_q.size() != 0 && bus.tx_ready) void'(m_q.pop_front());
        if (bus.mem_write && is_mmio && a[3:2] == 2'd0) begin
            if (m_q.size() < 8) m_q.push_back(bus.wdata[7:0]);
            else m_ovf = 1'b1;
        end
        if (bus.mem_write && is_mmio && a[3:2] == 2'd1) begin
            if (bus.wdata[2]) m_ovf = 1'b0;
            if (bus.wdata[3]) m_berr = 1'b0;
        end
        if ((bus.mem_read || bus.mem_write) && !is_ram && !is_mmio) m_berr = 1'b1;
        if (bus.mem_write && is_ram) m_ram[a / 4] = bus.wdata;
        if (bus.mem_write && is_mmio && a[3:2] == 2'd2) m_cycle = bus.wdata;
        else m_cycle = m_cycle + 32'd1;
    endtask

    task automatic set_bus(input logic [31:0] addr, input logic [31:0] wd,
                           input logic rd, input logic wr, input logic rdy);
        bus.address   = addr;
        bus.wdata     = wd;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.tx_ready  = rdy;
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
        n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
        set_bus(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h1) begin n_fail++; $display("FAIL reset_status got=%h exp=00000001", bus.rdata); end
        set_bus(32'hFFFF_0008, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_cycle got=%h exp=00000000", bus.rdata); end
        reset = 1'b1;
        model_reset();
        set_bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ram();
        logic [31:0] a;
        logic        rd, wr;
        logic [31:0] exp;
        set_bus(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0); cyc();
        set_bus(32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_load_10 got=%h exp=deadbeef", bus.rdata); end
        cyc();
        set_bus(32'h13, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_load_13 got=%h exp=deadbeef", bus.rdata); end
        cyc();
        set_bus(32'h14, 32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL ram_noread got=%h exp=0", bus.rdata); end
        cyc();
        // Fill every word so random reads always hit known data
        for (int i = 0; i < 256; i++) begin
            set_bus(32'(i * 4), $urandom, 1'b0, 1'b1, 1'b0); cyc();
        end
        set_bus(32'h20, 32'h1234_5678, 1'b0, 1'b1, 1'b0); cyc();
        set_bus(32'h20, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0);
        n_checks++; if (bus.rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_rw_prewrite got=%h exp=12345678", bus.rdata); end
        cyc();
        set_bus(32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_rw_after got=%h exp=cafef00d", bus.rdata); end
        cyc();
        for (int i = 0; i < 80; i++) begin
            a  = $urandom_range(0, 1023);
            rd = 1'($urandom);
            wr = 1'($urandom);
            set_bus(a, $urandom, rd, wr, 1'b0);
            exp = m_rdata(a, rd);
            n_checks++; if (bus.rdata !== exp) begin n_fail++; $display("FAIL ram_random addr=%h got=%h exp=%h", a, bus.rdata, exp); end
            cyc();
        end
        set_bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fifo_basic();
        set_bus(32'hFFFF_0000, 32'h41, 1'b0, 1'b1, 1'b0); cyc();
        set_bus(32'hFFFF_0000, 32'h42, 1'b0, 1'b1, 1'b0); cyc();
        set_bus(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h0000_0200) begin n_fail++; $display("FAIL fifo_status2 got=%h exp=00000200", bus.rdata); end
        n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin n_fail++; $display("FAIL fifo_head_hold got=%b/%h exp=1/41", bus.tx_valid, bus.tx_data); end
        cyc();
        set_bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.tx_data !== 8'h41) begin n_fail++; $display("FAIL fifo_out0 got=%h exp=41", bus.tx_data); end
        cyc();
        n_checks++; if (bus.tx_data !== 8'h42) begin n_fail++; $display("FAIL fifo_out1 got=%h exp=42", bus.tx_data); end
        cyc();
        set_bus(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.tx_valid !== 1'b0 || bus.rdata !== 32'h1) begin n_fail++; $display("FAIL fifo_drained got=%b/%h exp=0/00000001", bus.tx_valid, bus.rdata); end
        cyc();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            set_bus(32'hFFFF_0000, 32'(8'h50 + i), 1'b0, 1'b1, 1'b0); cyc();
        end
        set_bus(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h0000_0806) begin n_fail++; $display("FAIL ovf_status got=%h exp=00000806", bus.rdata); end
        cyc();
        set_bus(32'hFFFF_0004, 32'h4, 1'b0, 1'b1, 1'b0); cyc();
        set_bus(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h0000_0802) begin n_fail++; $display("FAIL ovf_clear got=%h exp=00000802", bus.rdata); end
        cyc();
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        set_bus(32'hFFFF_0000, 32'h99, 1'b0, 1'b1, 1'b1);
        n_checks++; if (bus.tx_data !== 8'h50) begin n_fail++; $display("FAIL full_pp_head got=%h exp=50", bus.tx_data); end
        cyc();
        set_bus(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h0000_0802) begin n_fail++; $display("FAIL full_pp_status got=%h exp=00000802", bus.rdata); end
        cyc();
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 8'(8'h51 + i) : 8'h99;
            set_bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            n_checks++; if (bus.tx_data !== exp) begin n_fail++; $display("FAIL full_pp_drain%0d got=%h exp=%h", i, bus.tx_data, exp); end
            cyc();
        end
        // Push and pop together with exactly one byte queued
        set_bus(32'hFFFF_0000, 32'h11, 1'b0, 1'b1, 1'b0); cyc();
        set_bus(32'hFFFF_0000, 32'h22, 1'b0, 1'b1, 1'b1);
        n_checks++; if (bus.tx_data !== 8'h11) begin n_fail++; $display("FAIL one_pp_before got=%h exp=11", bus.tx_data); end
        cyc();
        set_bus(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h0000_0100 || bus.tx_data !== 8'h22) begin n_fail++; $display("FAIL one_pp_after got=%h/%h exp=00000100/22", bus.rdata, bus.tx_data); end
        cyc();
        set_bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1); cyc();
    endtask

    task automatic test_cycle();
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFFE; exp[1] = 32'hFFFF_FFFF; exp[2] = 32'h0;
        set_bus(32'hFFFF_0008, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0); cyc();
        for (int i = 0; i < 3; i++) begin
            set_bus(32'hFFFF_0008, 32'h0, 1'b1, 1'b0, 1'b0);
            n_checks++; if (bus.rdata !== exp[i]) begin n_fail++; $display("FAIL cycle_wrap%0d got=%h exp=%h", i, bus.rdata, exp[i]); end
            cyc();
        end
    endtask

    task automatic test_bus_err_reset();
        set_bus(32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_rdata got=%h exp=0", bus.rdata); end
        cyc();
        set_bus(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h0000_0009) begin n_fail++; $display("FAIL berr_status got=%h exp=00000009", bus.rdata); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            set_bus(32'hFFFF_0000, 32'(8'hA0 + i), 1'b0, 1'b1, 1'b0); cyc();
        end
        set_bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.tx_valid !== 1'b1) begin n_fail++; $display("FAIL prereset_valid got=%b exp=1", bus.tx_valid); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_tx got=%b/%h exp=0/00", bus.tx_valid, bus.tx_data); end
        set_bus(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rdata !== 32'h1) begin n_fail++; $display("FAIL midreset_status got=%h exp=00000001", bus.rdata); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        set_bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        rd, wr;
        logic [31:0] exp;
        int          kind;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 3)      a = $urandom_range(0, 1023);
            else if (kind < 9) a = 32'hFFFF_0000 | ($urandom & 32'h0000_FFFF);
            else               a = $urandom_range(32'h0000_0400, 32'hFFFE_FFFF);
            rd = ($urandom_range(0, 2) != 0);
            wr = ($urandom_range(0, 2) == 0);
            set_bus(a, $urandom, rd, wr, ($urandom_range(0, 3) == 0));
            exp = m_rdata(a, rd);
            n_checks++; if (bus.rdata !== exp) begin n_fail++; $display("FAIL rnd_rdata i=%0d addr=%h got=%h exp=%h", i, a, bus.rdata, exp); end
            n_checks++; if (bus.tx_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_tx_valid i=%0d got=%b exp=%b", i, bus.tx_valid, (m_q.size() != 0)); end
            n_checks++; if (bus.tx_data !== m_txd()) begin n_fail++; $display("FAIL rnd_tx_data i=%0d got=%h exp=%h", i, bus.tx_data, m_txd()); end
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ram();
        test_fifo_basic();
        test_overflow();
        test_full_push_pop();
        test_cycle();
        test_bus_err_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
